hazard_ctrl: RTL and testbench

Parametrised hazard and stall controller for the in-order pipeline. It sits beside the ID and EX stages and generates the stall, bubble and flush controls for the PC, IF/ID and ID/EX registers. It handles four cases: load-use hazards with a configurable load latency, multi-cycle mul/div occupancy of EX, taken-branch flushes, and a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall, bubble and flush controller for the in-order pipeline. Sits beside
// ID and EX and drives the enables of PC, IF/ID and ID/EX.
//   - load-use hazard : freeze PC and IF/ID, inject LOAD_LAT bubbles into ID/EX
//   - mul/div in EX   : freeze PC, IF/ID and ID/EX while the unit is busy
//   - taken branch    : flush IF/ID and bubble ID/EX for one cycle
//   - stall_count     : saturating count of cycles with PCwrite=0
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   id_rs1/id_rs2     source registers of the ID instruction
//   id_rs1_used/_used operand-valid flags of the ID instruction
//   ex_rd             destination register of the EX instruction
//   ex_MemRead        EX instruction is a load
//   ex_muldiv         EX instruction is a multi-cycle mul/div
//   branch_taken      EX resolved a taken branch or jump
//   PCwrite           PC enable
//   IF_IDwrite        IF/ID enable
//   ID_EXwrite        ID/EX enable (0 holds EX)
//   control_sel       1 selects zeroed control into ID/EX (bubble)
//   IF_ID_flush       clear IF/ID to a NOP at the next edge
//   stall_count       saturating count of PCwrite=0 cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_MemRead,
    input  logic              ex_muldiv,
    input  logic              branch_taken,
    output logic              PCwrite,
    output logic              IF_IDwrite,
    output logic              ID_EXwrite,
    output logic              control_sel,
    output logic              IF_ID_flush,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int MAX_LAT = (LOAD_LAT > MULDIV_LAT) ? LOAD_LAT : MULDIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_LD      = 2'd1;
    localparam logic [1:0] S_MD_BUSY = 2'd2;
    localparam logic [1:0] S_MD_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]    state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          hazard;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign hazard = ex_MemRead && (ex_rd != '0) &&
                    ((id_rs1_used && (ex_rd == id_rs1)) ||
                     (id_rs2_used && (ex_rd == id_rs2)));

    always_comb begin
        // NOTE: every output and next-state term gets a default first so no
        // path through the case leaves a variable unassigned (no latches).
        PCwrite     = 1'b1;
        IF_IDwrite  = 1'b1;
        ID_EXwrite  = 1'b1;
        control_sel = 1'b0;
        IF_ID_flush = 1'b0;
        next_state  = state;
        next_cnt    = cnt;

        case (state)
            S_RUN, S_MD_DONE: begin
                next_state = S_RUN;
                if (branch_taken) begin
                    IF_ID_flush = 1'b1;
                    control_sel = 1'b1;
                end else if ((state == S_RUN) && ex_muldiv && (MULDIV_LAT > 1)) begin
                    // This cycle is the first of MULDIV_LAT-1 hold cycles; the
                    // cycle after the last hold is MD_DONE. cnt counts the
                    // MD_BUSY cycles still to come after the first one.
                    PCwrite    = 1'b0;
                    IF_IDwrite = 1'b0;
                    ID_EXwrite = 1'b0;
                    if (MULDIV_LAT > 2) begin
                        next_cnt   = CW'(MULDIV_LAT - 3);
                        next_state = S_MD_BUSY;
                    end else begin
                        next_cnt   = '0;
                        next_state = S_MD_DONE;
                    end
                end else if (hazard) begin
                    PCwrite     = 1'b0;
                    IF_IDwrite  = 1'b0;
                    control_sel = 1'b1;
                    if (LOAD_LAT > 1) begin
                        next_cnt   = CW'(LOAD_LAT - 2);
                        next_state = S_LD;
                    end
                end
            end

            // EX holds a bubble here, so branch/mul-div inputs are stale.
            S_LD: begin
                PCwrite     = 1'b0;
                IF_IDwrite  = 1'b0;
                control_sel = 1'b1;
                if (cnt == '0) next_state = S_RUN;
                else           next_cnt   = cnt - CW'(1);
            end

            S_MD_BUSY: begin
                PCwrite    = 1'b0;
                IF_IDwrite = 1'b0;
                ID_EXwrite = 1'b0;
                if (cnt == '0) next_state = S_MD_DONE;
                else           next_cnt   = cnt - CW'(1);
            end

            default: next_state = S_RUN;
        endcase

        // Reset takes effect on the outputs immediately, aborting any stall.
        if (reset) begin
            PCwrite     = 1'b1;
            IF_IDwrite  = 1'b1;
            ID_EXwrite  = 1'b1;
            control_sel = 1'b0;
            IF_ID_flush = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (!PCwrite && (stall_count != CNT_MAX))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Three instances share one stimulus stream:
//   dut_a : LOAD_LAT=1, MULDIV_LAT=4, CNT_W=16
//   dut_b : LOAD_LAT=3, MULDIV_LAT=4, CNT_W=16
//   dut_c : LOAD_LAT=1, MULDIV_LAT=1, CNT_W=2
// Control outputs are packed {PCwrite, IF_IDwrite, ID_EXwrite, control_sel,
// IF_ID_flush}. Inputs change just after the falling edge, outputs are sampled
// 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [4:0] C_RUN  = 5'b11100;
    localparam logic [4:0] C_LD   = 5'b00110;
    localparam logic [4:0] C_HOLD = 5'b00000;
    localparam logic [4:0] C_BR   = 5'b11111;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_MemRead, ex_muldiv, branch_taken;

    wire [4:0]  a_ctl, b_ctl, c_ctl;
    wire [15:0] a_sc, b_sc;
    wire [1:0]  c_sc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .MULDIV_LAT(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_muldiv(ex_muldiv),
        .branch_taken(branch_taken),
        .PCwrite(a_ctl[4]), .IF_IDwrite(a_ctl[3]), .ID_EXwrite(a_ctl[2]),
        .control_sel(a_ctl[1]), .IF_ID_flush(a_ctl[0]),
        .stall_count(a_sc)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .MULDIV_LAT(4), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_muldiv(ex_muldiv),
        .branch_taken(branch_taken),
        .PCwrite(b_ctl[4]), .IF_IDwrite(b_ctl[3]), .ID_EXwrite(b_ctl[2]),
        .control_sel(b_ctl[1]), .IF_ID_flush(b_ctl[0]),
        .stall_count(b_sc)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .MULDIV_LAT(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_muldiv(ex_muldiv),
        .branch_taken(branch_taken),
        .PCwrite(c_ctl[4]), .IF_IDwrite(c_ctl[3]), .ID_EXwrite(c_ctl[2]),
        .control_sel(c_ctl[1]), .IF_ID_flush(c_ctl[0]),
        .stall_count(c_sc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; returns 1 time unit after the inputs settle.
    task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic md, input logic br);
        @(negedge clk);
        reset        = rst;
        ex_MemRead   = mr;
        ex_rd        = rd;
        id_rs1       = r1;
        id_rs1_used  = u1;
        id_rs2       = r2;
        id_rs2_used  = u2;
        ex_muldiv    = md;
        branch_taken = br;
        #1;
    endtask

    initial begin
        reset = 1'b1; ex_MemRead = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_muldiv = 1'b0; branch_taken = 1'b0;

        // 0: reset held, outputs at run values
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_ctl_a", a_ctl, C_RUN);
        // 1: out of reset, idle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_ctl_a", a_ctl, C_RUN);
        check("idle_sc_a", a_sc, 0);
        check("idle_sc_b", b_sc, 0);
        check("idle_sc_c", c_sc, 0);

        // 2: load-use on rs1 (rd=5, rs1=5, rs2=7)
        drive(0, 1, 5, 5, 1, 7, 0, 0, 0);
        check("lu1_ctl_a", a_ctl, C_LD);
        check("lu3_c0_ctl_b", b_ctl, C_LD);
        // 3: load gone; LOAD_LAT=1 resumes, LOAD_LAT=3 keeps bubbling
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu1_after_ctl_a", a_ctl, C_RUN);
        check("lu1_sc_a", a_sc, 1);
        check("lu3_c1_ctl_b", b_ctl, C_LD);
        // 4
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu3_c2_ctl_b", b_ctl, C_LD);
        // 5
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu3_done_ctl_b", b_ctl, C_RUN);
        check("lu3_sc_b", b_sc, 3);

        // 6: load to x0 matching both operands
        drive(0, 1, 0, 0, 1, 0, 1, 0, 0);
        check("x0_ctl_a", a_ctl, C_RUN);
        // 7: rd=9 matches rs2 only
        drive(0, 1, 9, 3, 1, 9, 1, 0, 0);
        check("rs2_ctl_a", a_ctl, C_LD);
        // 8: same match, rs2 unused
        drive(0, 1, 9, 3, 1, 9, 0, 0, 0);
        check("rs2_unused_ctl_a", a_ctl, C_RUN);
        check("ld_ignores_ctl_b", b_ctl, C_LD);
        // 9
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rs2_sc_a", a_sc, 2);

        // 10-12: mul/div holds EX for 3 cycles
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("md_h0_ctl_a", a_ctl, C_HOLD);
        check("md_lat1_ctl_c", c_ctl, C_RUN);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("md_h1_ctl_a", a_ctl, C_HOLD);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("md_h2_ctl_a", a_ctl, C_HOLD);
        // 13: MD_DONE, no re-trigger
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("md_done_ctl_a", a_ctl, C_RUN);
        check("md_sc_a", a_sc, 5);
        // 14-16: back-to-back mul/div, branch ignored while busy
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("md2_h0_ctl_a", a_ctl, C_HOLD);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("md2_h1_br_ctl_a", a_ctl, C_HOLD);
        check("br_ctl_c", c_ctl, C_BR);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("md2_h2_ctl_a", a_ctl, C_HOLD);
        // 17: branch in MD_DONE is honoured
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("md_done_br_ctl_a", a_ctl, C_BR);
        check("md2_sc_a", a_sc, 8);

        // 18: branch beats load-use
        drive(0, 1, 5, 5, 1, 0, 0, 0, 1);
        check("br_prio_ctl_a", a_ctl, C_BR);
        check("br_prio_ctl_b", b_ctl, C_BR);
        // 19
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("br_nostall_sc_a", a_sc, 8);
        check("total_sc_b", b_sc, 12);
        check("pre_sat_sc_c", c_sc, 2);

        // 20-22: continuous load-use stalls
        drive(0, 1, 5, 5, 1, 0, 0, 0, 0);
        check("cont_ctl_c", c_ctl, C_LD);
        drive(0, 1, 5, 5, 1, 0, 0, 0, 0);
        check("sat_sc_c", c_sc, 3);
        drive(0, 1, 5, 5, 1, 0, 0, 0, 0);
        check("sat_hold_sc_c", c_sc, 3);
        // 23: start a mul/div on a
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("sat_final_sc_c", c_sc, 3);
        check("cont_sc_a", a_sc, 11);
        check("md3_h0_ctl_a", a_ctl, C_HOLD);
        // 24: reset while in MD_BUSY
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        check("rst_md_ctl_a", a_ctl, C_RUN);
        check("rst_md_sc_a", a_sc, 12);
        // 25: after reset edge
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_ctl_a", a_ctl, C_RUN);
        check("post_rst_sc_a", a_sc, 0);
        check("post_rst_sc_b", b_sc, 0);
        check("post_rst_sc_c", c_sc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
